// File: rtl/fire7_ofm_ram_writer_pkg.sv
// Shared types and default-derived constants for the fire7 output feature-map RAM writer.
// Modules re-derive BEATS/AW from their own parameters; the values here match the defaults.
package fire7_ofm_ram_writer_pkg;

  localparam int WOUT_DEF   = 16;
  localparam int DSP_NO_DEF = 192;
  localparam int WIDTH_DEF  = 16;
  localparam int LANES_DEF  = 4;

  localparam int BEATS = DSP_NO_DEF / LANES_DEF;
  localparam int AW    = $clog2(WOUT_DEF * WOUT_DEF * BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Counter width that stays at least one bit when the count collapses to 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fire7_ofm_lane_mux.sv
// Selects the LANES-word slice of the holding buffer addressed by the current beat.
module fire7_ofm_lane_mux
  import fire7_ofm_ram_writer_pkg::*;
#(
  parameter int DSP_NO = DSP_NO_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int BW     = clog2_min1(DSP_NO / LANES)
) (
  input  logic [DSP_NO*WIDTH-1:0] hold,
  input  logic [BW-1:0]           beat,
  output logic [LANES*WIDTH-1:0]  slice
);

  localparam int DW = LANES * WIDTH;

  // Word beat*LANES+k lands in lane k because word 0 sits in the buffer's LSBs.
  always_comb begin
    slice = hold[int'(beat)*DW +: DW];
  end

endmodule

// File: rtl/fire7_ofm_ram_writer.sv
// Captures a DSP_NO-word pixel vector and drains it to the OFM RAM, LANES words per beat,
// one pixel after another until WOUT*WOUT pixels are written.
module fire7_ofm_ram_writer
  import fire7_ofm_ram_writer_pkg::*;
#(
  parameter int WOUT   = WOUT_DEF,
  parameter int DSP_NO = DSP_NO_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LANES  = LANES_DEF,
  localparam int BEAT_CNT = DSP_NO / LANES,
  localparam int ADDR_W   = $clog2(WOUT * WOUT * BEAT_CNT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              layer_sample,
  input  logic [DSP_NO-1:0][WIDTH-1:0]      ofm,
  output logic                              ram_we,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic [LANES*WIDTH-1:0]            ram_wdata,
  output logic                              ram_feedback,
  output logic                              busy,
  output logic                              overflow_err
);

  localparam int NPIX = WOUT * WOUT;
  localparam int BW   = clog2_min1(BEAT_CNT);
  localparam int PW   = $clog2(NPIX + 1);
  localparam int DW   = LANES * WIDTH;

  state_e                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [PW-1:0]           pixel_q, pixel_d;
  logic                    capture, ovf_set;
  logic                    last_beat, last_pixel;
  logic [DSP_NO*WIDTH-1:0] hold_q;
  logic [DW-1:0]           lane_data, wdata_q;
  logic [ADDR_W-1:0]       addr_live, addr_q;

  assign last_beat  = (beat_q == BW'(BEAT_CNT - 1));
  assign last_pixel = (pixel_q == PW'(NPIX - 1));
  assign addr_live  = ADDR_W'(int'(pixel_q) * BEAT_CNT + int'(beat_q));

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pixel_d = pixel_q;
    capture = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (layer_sample) begin
          capture = 1'b1;
          beat_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_beat) begin
          pixel_d = pixel_q + 1'b1;
          beat_d  = '0;
          if (last_pixel) begin
            state_d = ST_DONE;
          end else if (layer_sample) begin
            capture = 1'b1;                 // chained sample: stay in DRAIN with no gap
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_d  = beat_q + 1'b1;
          ovf_set = layer_sample;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      pixel_q      <= '0;
      overflow_err <= 1'b0;
      ram_feedback <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      pixel_q      <= pixel_d;
      ram_feedback <= (state_q == ST_DRAIN) && (state_d == ST_DONE);
      if (ovf_set) begin
        overflow_err <= 1'b1;
      end
      if (state_q == ST_DRAIN) begin
        addr_q  <= addr_live;
        wdata_q <= lane_data;
      end
    end
  end

  // NOTE: the holding buffer is wide datapath storage, only read after a capture, so it has no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_q <= ofm;
    end
  end

  fire7_ofm_lane_mux #(
    .DSP_NO(DSP_NO),
    .WIDTH (WIDTH),
    .LANES (LANES),
    .BW    (BW)
  ) u_lane_mux (
    .hold (hold_q),
    .beat (beat_q),
    .slice(lane_data)
  );

  // Address/data follow the drain live and hold their last written value otherwise.
  assign busy      = (state_q == ST_DRAIN);
  assign ram_we    = busy;
  assign ram_addr  = ram_we ? addr_live : addr_q;
  assign ram_wdata = ram_we ? lane_data : wdata_q;

endmodule

// File: doc/fire7_ofm_ram_writer.md
FIRE7_OFM_RAM_WRITER -- requirements
Module: fire7_ofm_ram_writer

Interface
REQ-001 Parameter WOUT, default 16, output feature-map side; pixels per layer = WOUT**2.
REQ-002 Parameter DSP_NO, default 192, output channels presented per sample.
REQ-003 Parameter WIDTH, default 16, bits per channel word.
REQ-004 Parameter LANES, default 4, channel words written per RAM beat; DSP_NO SHALL be a multiple of LANES.
REQ-005 Derived constants: BEATS = DSP_NO/LANES (48); AW = clog2(WOUT**2*BEATS) (14).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 layer_sample  input  1  one-cycle pulse; ofm holds a valid pixel vector in this cycle.
REQ-009 ofm  input  DSP_NO x WIDTH  per-channel results from the expand layer.
REQ-010 ram_we  output  1  write strobe to output feature-map RAM.
REQ-011 ram_addr  output  AW  RAM word address.
REQ-012 ram_wdata  output  LANES*WIDTH  RAM write data; lane 0 in bits WIDTH-1:0.
REQ-013 ram_feedback  output  1  one-cycle pulse when all WOUT**2 pixels are written.
REQ-014 busy  output  1  high while a captured vector is being drained.
REQ-015 overflow_err  output  1  sticky; a sample arrived that could not be accepted.

Function
REQ-016 FSM states: IDLE, DRAIN, DONE.
REQ-017 IDLE: layer_sample SHALL copy all DSP_NO words into a holding buffer and enter DRAIN; beat counter = 0.
REQ-018 DRAIN: each cycle, ram_we = 1; ram_wdata lane k = buffer[beat*LANES+k]; ram_addr = pixel*BEATS + beat; beat increments.
REQ-019 Latency: sample in cycle T -> first write in cycle T+1; last write (beat BEATS-1) in cycle T+BEATS.
REQ-020 On last beat: pixel increments; if the new pixel = WOUT**2, enter DONE, else enter IDLE.
REQ-021 Simultaneous: layer_sample during the last DRAIN beat SHALL be accepted (capture, beat = 0, stay in DRAIN; no idle cycle).
REQ-022 layer_sample in DRAIN on any other beat SHALL be dropped, buffer unchanged, overflow_err set.
REQ-023 ram_feedback SHALL pulse high for exactly the cycle after the final write (DONE entry cycle).
REQ-024 DONE: ram_we = 0; further layer_sample pulses ignored silently (no overflow_err); exit only by rst.
REQ-025 ram_we = 0 outside DRAIN; ram_addr/ram_wdata hold last value when ram_we = 0.
REQ-026 busy = 1 exactly in DRAIN.
REQ-027 No arithmetic on data; words pass bit-exact.

Reset
REQ-028 rst SHALL force IDLE, pixel = 0, beat = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, ram_feedback = 0, overflow_err = 0, busy = 0.
REQ-029 rst mid-DRAIN SHALL abort the drain; no write in the reset cycles; holding buffer need not be cleared.

Structure
REQ-030 Shared package holds FSM state enum and derived constants BEATS, AW.
REQ-031 One sub-module: fire7_ofm_lane_mux (buffer + beat -> LANES-word slice); rest in this module.

Verification
REQ-032 Single sample, ofm[i] = i -> 48 writes at T+1..T+48, addr 0..47, first wdata = {3,2,1,0}, last = {191,190,189,188}.
REQ-033 Samples every 65 cycles for 256 pixels -> 12288 writes, final addr 12287, ram_feedback one pulse, overflow_err = 0.
REQ-034 Back-to-back: second sample on beat 47 -> continuous ram_we, addr 48 on the next cycle, no error.
REQ-035 Second sample on beat 10 -> overflow_err = 1, dropped, addresses continue 11..47 with first vector data.
REQ-036 rst asserted at beat 20 of pixel 5 -> ram_we = 0 immediately; next sample writes addr 0.
REQ-037 Extra samples after DONE -> no writes, no ram_feedback, overflow_err stays 0.
